// File: rtl/dfi_bist_pkg.sv
// Shared definitions for the DFI BIST error logger: beat count, log entry
// sizing and a saturating increment used by every statistics counter.
package dfi_bist_pkg;

    // One DFI read word carries this many beats of MEM_DQ_WIDTH bits.
    localparam int BEATS = 8;

    // Width of one log entry: {timestamp, group mask, per-bit error mask}.
    function automatic int entry_width(input int ts_w, input int dqs_w, input int dq_w);
        return ts_w + dqs_w + dq_w * BEATS;
    endfunction

    // Increment that sticks at the all-ones value of a 'width'-bit counter
    // (width 1..32); callers truncate the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/dfi_bist_err_fifo.sv
// First-word-fall-through FIFO built on a register array. The head entry is
// read combinationally from storage so it is visible the cycle after the push.
// A pop and a push in the same cycle are both honoured, even when full.
module dfi_bist_err_fifo
    import dfi_bist_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             core_clk,
    input  logic             core_clk_rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_pop;
    logic             do_push;

    // Extra pointer MSB separates the full and empty cases.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr_reg[AW-1:0]];

    // Pointer update; clear empties the FIFO and overrides push/pop.
    always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
        if (!core_clk_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge core_clk) begin
        if (do_push && !clear) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dfi_bist_err_logger.sv
// Error logger behind the DFI read-data checker: timestamps each error event
// into a FWFT log, keeps per-byte-group saturating error counts, a sticky
// per-DQ-lane error map and a count of events lost to a full log.
module dfi_bist_err_logger
    import dfi_bist_pkg::*;
#(
    parameter int MEM_DQ_WIDTH  = 16,
    parameter int MEM_DQS_WIDTH = 2,
    parameter int LOG_AW        = 4,
    parameter int TS_WIDTH      = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                               core_clk,
    input  logic                               core_clk_rst_n,
    input  logic                               ddrphy_init_done,
    input  logic                               manu_clear,
    input  logic                               err_valid,
    input  logic [MEM_DQS_WIDTH-1:0]           err_group,
    input  logic [MEM_DQ_WIDTH*8-1:0]          err_data,
    input  logic [MEM_DQ_WIDTH*8-1:0]          exp_data,
    output logic                               log_valid,
    input  logic                               log_ready,
    output logic [TS_WIDTH-1:0]                log_ts,
    output logic [MEM_DQS_WIDTH-1:0]           log_group,
    output logic [MEM_DQ_WIDTH*8-1:0]          log_bitmask,
    output logic [LOG_AW:0]                    log_level,
    output logic                               log_overflow,
    output logic [CNT_WIDTH-1:0]               drop_cnt,
    output logic [MEM_DQ_WIDTH-1:0]            lane_err_sticky,
    output logic [MEM_DQS_WIDTH*CNT_WIDTH-1:0] group_err_cnt
);

    localparam int WORD_W  = MEM_DQ_WIDTH * BEATS;
    localparam int ENTRY_W = entry_width(TS_WIDTH, MEM_DQS_WIDTH, MEM_DQ_WIDTH);

    logic [TS_WIDTH-1:0]     ts_reg;
    logic [WORD_W-1:0]       bitmask;
    logic [ENTRY_W-1:0]      push_data;
    logic [ENTRY_W-1:0]      head_data;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    event_drop;
    logic                    event_live;
    logic [MEM_DQ_WIDTH-1:0] lane_hit;
    logic                    overflow_reg;
    logic [CNT_WIDTH-1:0]    drop_cnt_reg;
    logic [MEM_DQ_WIDTH-1:0] lane_reg;

    // An event coinciding with manu_clear is discarded everywhere.
    assign event_live = err_valid && !manu_clear;
    assign bitmask    = err_data ^ exp_data;
    assign push_data  = {ts_reg, err_group, bitmask};
    assign fifo_push  = event_live;
    assign fifo_pop   = log_valid && log_ready;
    // Lost only when full and no pop frees a slot this cycle.
    assign event_drop = event_live && fifo_full && !fifo_pop;

    dfi_bist_err_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (LOG_AW)
    ) u_fifo (
        .core_clk       (core_clk),
        .core_clk_rst_n (core_clk_rst_n),
        .clear          (manu_clear),
        .push           (fifo_push),
        .push_data      (push_data),
        .pop            (fifo_pop),
        .head_data      (head_data),
        .empty          (fifo_empty),
        .full           (fifo_full),
        .level          (log_level)
    );

    // Head fields are forced to zero while the log is empty.
    assign log_valid   = !fifo_empty;
    assign log_ts      = log_valid ? head_data[ENTRY_W-1 -: TS_WIDTH]     : '0;
    assign log_group   = log_valid ? head_data[WORD_W +: MEM_DQS_WIDTH]   : '0;
    assign log_bitmask = log_valid ? head_data[WORD_W-1:0]                : '0;

    // Free-running timestamp while the PHY is initialised; clear leaves it alone.
    always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
        if (!core_clk_rst_n)       ts_reg <= '0;
        else if (ddrphy_init_done) ts_reg <= ts_reg + TS_WIDTH'(1);
    end

    // Fold the eight beats of the error mask onto the DQ lanes.
    always_comb begin
        lane_hit = '0;
        for (int b = 0; b < BEATS; b++) begin
            lane_hit = lane_hit | bitmask[b*MEM_DQ_WIDTH +: MEM_DQ_WIDTH];
        end
    end

    // Sticky lane map; dropped events still mark their lanes.
    always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
        if (!core_clk_rst_n)  lane_reg <= '0;
        else if (manu_clear)  lane_reg <= '0;
        else if (err_valid)   lane_reg <= lane_reg | lane_hit;
    end

    // Sticky overflow flag and saturating count of dropped events.
    always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
        if (!core_clk_rst_n) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (manu_clear) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (event_drop) begin
            overflow_reg <= 1'b1;
            drop_cnt_reg <= CNT_WIDTH'(sat_inc(32'(drop_cnt_reg), CNT_WIDTH));
        end
    end

    assign log_overflow    = overflow_reg;
    assign drop_cnt        = drop_cnt_reg;
    assign lane_err_sticky = lane_reg;

    // One saturating error counter per DQS group, dropped events included.
    generate
        for (genvar gi = 0; gi < MEM_DQS_WIDTH; gi++) begin : g_grp_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;

            // Count events that flag this group.
            always_ff @(posedge core_clk or negedge core_clk_rst_n) begin
                if (!core_clk_rst_n)                  cnt_reg <= '0;
                else if (manu_clear)                  cnt_reg <= '0;
                else if (err_valid && err_group[gi])  cnt_reg <= CNT_WIDTH'(sat_inc(32'(cnt_reg), CNT_WIDTH));
            end

            assign group_err_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_dfi_bist_err_logger.sv
// Scoreboard bench for dfi_bist_err_logger: stimulus pushes expected log
// entries into a queue, a negedge monitor pops and compares every entry the
// DUT hands over. Status outputs are checked directly against hand values.
module tb_dfi_bist_err_logger;

    localparam int DQ  = 16;
    localparam int DQS = 2;
    localparam int AW  = 4;
    localparam int TSW = 32;
    localparam int CW  = 16;

    logic            core_clk;
    logic            core_clk_rst_n;
    logic            ddrphy_init_done;
    logic            manu_clear;
    logic            err_valid;
    logic [DQS-1:0]  err_group;
    logic [DQ*8-1:0] err_data;
    logic [DQ*8-1:0] exp_data;
    logic            log_valid;
    logic            log_ready;
    logic [TSW-1:0]  log_ts;
    logic [DQS-1:0]  log_group;
    logic [DQ*8-1:0] log_bitmask;
    logic [AW:0]     log_level;
    logic            log_overflow;
    logic [CW-1:0]   drop_cnt;
    logic [DQ-1:0]   lane_err_sticky;
    logic [DQS*CW-1:0] group_err_cnt;

    // Second instance with 4-bit counters for the saturation check.
    logic            sat_err_valid;
    logic [DQS-1:0]  sat_group;
    logic            sat_ready;
    logic            sat_log_valid;
    logic [TSW-1:0]  sat_log_ts;
    logic [DQS-1:0]  sat_log_group;
    logic [DQ*8-1:0] sat_log_bitmask;
    logic [AW:0]     sat_log_level;
    logic            sat_log_overflow;
    logic [3:0]      sat_drop_cnt;
    logic [DQ-1:0]   sat_lane;
    logic [DQS*4-1:0] sat_grp_cnt;

    typedef struct packed {
        logic [TSW-1:0]  ts;
        logic [DQS-1:0]  grp;
        logic [DQ*8-1:0] mask;
    } entry_t;

    entry_t sb_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    logic [TSW-1:0] ts_m;

    dfi_bist_err_logger #(
        .MEM_DQ_WIDTH(DQ), .MEM_DQS_WIDTH(DQS), .LOG_AW(AW), .TS_WIDTH(TSW), .CNT_WIDTH(CW)
    ) dut (
        .core_clk        (core_clk),
        .core_clk_rst_n  (core_clk_rst_n),
        .ddrphy_init_done(ddrphy_init_done),
        .manu_clear      (manu_clear),
        .err_valid       (err_valid),
        .err_group       (err_group),
        .err_data        (err_data),
        .exp_data        (exp_data),
        .log_valid       (log_valid),
        .log_ready       (log_ready),
        .log_ts          (log_ts),
        .log_group       (log_group),
        .log_bitmask     (log_bitmask),
        .log_level       (log_level),
        .log_overflow    (log_overflow),
        .drop_cnt        (drop_cnt),
        .lane_err_sticky (lane_err_sticky),
        .group_err_cnt   (group_err_cnt)
    );

    dfi_bist_err_logger #(
        .MEM_DQ_WIDTH(DQ), .MEM_DQS_WIDTH(DQS), .LOG_AW(AW), .TS_WIDTH(TSW), .CNT_WIDTH(4)
    ) dut_sat (
        .core_clk        (core_clk),
        .core_clk_rst_n  (core_clk_rst_n),
        .ddrphy_init_done(ddrphy_init_done),
        .manu_clear      (manu_clear),
        .err_valid       (sat_err_valid),
        .err_group       (sat_group),
        .err_data        (err_data),
        .exp_data        (exp_data),
        .log_valid       (sat_log_valid),
        .log_ready       (sat_ready),
        .log_ts          (sat_log_ts),
        .log_group       (sat_log_group),
        .log_bitmask     (sat_log_bitmask),
        .log_level       (sat_log_level),
        .log_overflow    (sat_log_overflow),
        .drop_cnt        (sat_drop_cnt),
        .lane_err_sticky (sat_lane),
        .group_err_cnt   (sat_grp_cnt)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // Reference timestamp: counts edges while init_done is high.
    always @(posedge core_clk or negedge core_clk_rst_n) begin
        if (!core_clk_rst_n)       ts_m <= '0;
        else if (ddrphy_init_done) ts_m <= ts_m + 32'd1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expectation.
    always @(negedge core_clk) begin
        if (core_clk_rst_n && log_valid && log_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry: got ts=%0d grp=%b, expected no entry", log_ts, log_group);
            end else begin
                entry_t e;
                e = sb_q.pop_front();
                $display("pop   ts=%0d grp=%b mask=%0h", log_ts, log_group, log_bitmask);
                check("entry_ts",   128'(log_ts),    128'(e.ts));
                check("entry_grp",  128'(log_group), 128'(e.grp));
                check("entry_mask", log_bitmask,     e.mask);
            end
        end
    end

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    // Issue one error event this cycle; optionally expect it in the log.
    task automatic send(input logic [DQS-1:0] grp, input logic [DQ*8-1:0] mask, input bit logged);
        logic [DQ*8-1:0] rnd;
        rnd       = {$urandom, $urandom, $urandom, $urandom};
        err_valid = 1'b1;
        err_group = grp;
        err_data  = rnd ^ mask;
        exp_data  = rnd;
        if (logged) sb_q.push_back('{ts: ts_m, grp: grp, mask: mask});
        $display("event ts=%0d grp=%b mask=%0h logged=%0d", ts_m, grp, mask, logged);
        step();
        err_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},    128'(log_valid),       128'(0));
        check({tag, "_level"},    128'(log_level),       128'(0));
        check({tag, "_overflow"}, 128'(log_overflow),    128'(0));
        check({tag, "_drop"},     128'(drop_cnt),        128'(0));
        check({tag, "_cnt"},      128'(group_err_cnt),   128'(0));
        check({tag, "_lanes"},    128'(lane_err_sticky), 128'(0));
    endtask

    initial begin
        logic [DQ*8-1:0] m;
        bit found;
        core_clk_rst_n   = 1'b0;
        ddrphy_init_done = 1'b0;
        manu_clear       = 1'b0;
        err_valid        = 1'b0;
        err_group        = '0;
        err_data         = '0;
        exp_data         = '0;
        log_ready        = 1'b0;
        sat_err_valid    = 1'b0;
        sat_group        = 2'b01;
        sat_ready        = 1'b0;

        // Reset state
        step(); step();
        check_all_zero("reset");
        check("reset_ts",   128'(log_ts),      128'(0));
        check("reset_mask", log_bitmask,       128'(0));
        core_clk_rst_n = 1'b1;
        step(); step(); step();

        // Timestamp held at 0 without init_done; all-zero group/mask still logged
        log_ready = 1'b1;
        send(2'b00, '0, 1'b1);
        step(); step();
        check("zero_evt_cnt",   128'(group_err_cnt),   128'(0));
        check("zero_evt_lanes", 128'(lane_err_sticky), 128'(0));

        // Single error at ts=100
        log_ready        = 1'b0;
        ddrphy_init_done = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ts_m == 32'd100) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("ts_reach_100", 128'(found), 128'(1));
        send(2'b01, 128'h20, 1'b1);
        check("single_valid", 128'(log_valid),       128'(1));
        check("single_ts",    128'(log_ts),          128'(100));
        check("single_level", 128'(log_level),       128'(1));
        check("single_lanes", 128'(lane_err_sticky), 128'h0020);
        check("single_cnt0",  128'(group_err_cnt[15:0]), 128'(1));
        log_ready = 1'b1;
        step();
        check("single_drained", 128'(log_valid), 128'(0));

        // Overflow: 17 events into a 16-deep log with no consumer
        log_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            m = (i == 16) ? (128'h8000 << (3*DQ)) : (128'(i+1) << (7*DQ));
            send(2'b10, m, i < 16);
        end
        check("ovf_level", 128'(log_level),          128'(16));
        check("ovf_flag",  128'(log_overflow),       128'(1));
        check("ovf_drop",  128'(drop_cnt),           128'(1));
        check("ovf_cnt1",  128'(group_err_cnt[31:16]), 128'(17));
        check("ovf_cnt0",  128'(group_err_cnt[15:0]),  128'(1));
        check("ovf_lanes", 128'(lane_err_sticky),    128'h803F);
        log_ready = 1'b1;
        for (int i = 0; i < 16; i++) step();
        check("ovf_drained_valid", 128'(log_valid),   128'(0));
        check("ovf_drained_q",     128'(sb_q.size()), 128'(0));

        // Full log with simultaneous push and pop
        log_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(2'b10, 128'(i) << DQ, 1'b1);
        check("full_level", 128'(log_level), 128'(16));
        log_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(2'b01, 128'(16'hA000 + i), 1'b1);
            check("fullpp_level", 128'(log_level), 128'(16));
        end
        check("fullpp_drop", 128'(drop_cnt),     128'(1));
        check("fullpp_ovf",  128'(log_overflow), 128'(1));

        // manu_clear with a coincident event part-way through a drain
        step(); step(); step();
        check("predrain_level", 128'(log_level), 128'(13));
        manu_clear = 1'b1;
        send(2'b11, 128'hFFFF, 1'b0);
        manu_clear = 1'b0;
        sb_q.delete();
        check_all_zero("clear");
        log_ready = 1'b0;
        send(2'b11, 128'(1) << (2*DQ), 1'b1);
        check("postclr_cnt",   128'(group_err_cnt),   {96'd0, 16'd1, 16'd1});
        check("postclr_lanes", 128'(lane_err_sticky), 128'h0001);
        check("postclr_level", 128'(log_level),       128'(1));
        log_ready = 1'b1;
        step(); step();

        // Asynchronous reset during a drain
        log_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'b01, 128'(i + 1), 1'b1);
        log_ready = 1'b1;
        step();
        #1 core_clk_rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        check("arst_ts",   128'(log_ts),      128'(0));
        check("arst_mask", log_bitmask,       128'(0));
        #1 core_clk_rst_n = 1'b1;
        sb_q.delete();
        step();
        send(2'b10, 128'h4, 1'b1);
        check("arst_resume_cnt1", 128'(group_err_cnt[31:16]), 128'(1));
        step(); step();
        check("arst_resume_level", 128'(log_level), 128'(0));

        // Saturation on the 4-bit-counter instance
        for (int i = 0; i < 20; i++) begin
            sat_err_valid = 1'b1;
            step();
            if (i == 14) check("sat_at_15", 128'(sat_grp_cnt[3:0]), 128'(15));
        end
        sat_err_valid = 1'b0;
        step();
        check("sat_hold",  128'(sat_grp_cnt[3:0]), 128'(15));
        check("sat_other", 128'(sat_grp_cnt[7:4]), 128'(0));
        check("sat_drop",  128'(sat_drop_cnt),     128'(4));

        check("final_queue_empty", 128'(sb_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
